logic_eval_lanes: RTL and testbench

- Parametrised, clocked successor to the team's single-lane AND/OR/NOT evaluator (x = (A&B) | ~C, y = ~C).
- Evaluates LANES independent 3-input lanes through a 2-stage registered pipeline.
- Mode is selectable at runtime.
- Each lane's x has a consecutive-sample glitch filter.
- A saturating, clearable counter tallies filtered rising edges across all lanes. Sits between the tile's ui_in pins and uo_out/status logic.

---
 rtl/logic_eval_pkg.sv | 27 ++
 rtl/logic_eval_filter.sv | 39 +++
 rtl/logic_eval_lanes.sv | 105 ++++++++++
 tb/tb_logic_eval_lanes.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_eval_pkg.sv
// Shared types and helpers for the multi-lane AND/OR/NOT evaluator.
package logic_eval_pkg;

  typedef enum logic [1:0] {
    MODE_AOI = 2'd0,
    MODE_MAJ = 2'd1,
    MODE_XOR = 2'd2,
    MODE_OAI = 2'd3
  } mode_e;

  localparam int unsigned FILT_DEPTH_DEF = 3;

  function automatic logic lane_eval(input mode_e mode, input logic a, input logic b,
                                     input logic c);
    logic r;
    r = 1'b0;
    case (mode)
      MODE_AOI: r = (a & b) | ~c;
      MODE_MAJ: r = (a & b) | (b & c) | (a & c);
      MODE_XOR: r = a ^ b ^ c;
      MODE_OAI: r = (a | b) & ~c;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_eval_filter.sv
// One lane's glitch filter: x_filt follows x only after FILT_DEPTH consecutive valid disagreeing samples.
module logic_eval_filter
  import logic_eval_pkg::*;
#(
  parameter int unsigned FILT_DEPTH = FILT_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic x,
  output logic x_filt,
  output logic rise
);

  localparam int unsigned FW = $clog2(FILT_DEPTH + 1);
  localparam logic [FW-1:0] LAST = FW'(FILT_DEPTH - 1);

  logic [FW-1:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt   <= '0;
      x_filt <= 1'b0;
    end else if (vld) begin
      if (x == x_filt) begin
        fcnt <= '0;
      end else if (fcnt == LAST) begin
        x_filt <= x;
        fcnt   <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Asserted in the cycle whose clock edge will move x_filt from 0 to 1.
  assign rise = vld & x & ~x_filt & (fcnt == LAST);

endmodule

// File: rtl/logic_eval_lanes.sv
// LANES-wide 2-stage registered evaluator with per-lane glitch filters and a saturating edge counter.
module logic_eval_lanes
  import logic_eval_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned FILT_DEPTH = FILT_DEPTH_DEF,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  output logic [LANES-1:0] x,
  output logic [LANES-1:0] y,
  output logic [LANES-1:0] x_filt,
  output logic             out_vld,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             evt_sat
);

  localparam int unsigned IW = $clog2(LANES + 1);
  localparam int unsigned SW = ((CNT_W > IW) ? CNT_W : IW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LANES-1:0] s1_a, s1_b, s1_c;
  mode_e            s1_mode;
  logic             s1_vld;
  logic [LANES-1:0] x_next;
  logic [LANES-1:0] rise;
  logic [IW-1:0]    inc;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a    <= '0;
      s1_b    <= '0;
      s1_c    <= '0;
      s1_mode <= MODE_AOI;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= en;
      if (en) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_c    <= c;
        s1_mode <= mode_e'(mode);
      end
    end
  end

  always_comb begin
    x_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      x_next[i] = lane_eval(s1_mode, s1_a[i], s1_b[i], s1_c[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        x <= x_next;
        y <= ~s1_c;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_filt
    logic_eval_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt (
      .clk    (clk),
      .rst    (rst),
      .vld    (out_vld),
      .x      (x[g]),
      .x_filt (x_filt[g]),
      .rise   (rise[g])
    );
  end

  // Clear restarts from zero but still counts edges landing on the same cycle.
  always_comb begin
    inc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      inc = inc + IW'(rise[i]);
    end
    sum      = (cnt_clr ? '0 : SW'(evt_cnt)) + SW'(inc);
    cnt_next = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_cnt <= '0;
    else     evt_cnt <= cnt_next;
  end

  assign evt_sat = (evt_cnt == CNT_MAX);

endmodule

// File: tb/tb_logic_eval_lanes.sv
// Self-checking bench: scoreboarded x/y results, hand sequences for filter, counter and reset corners.
module tb_logic_eval_lanes;

  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         rst, en, cnt_clr;
  logic [1:0]   mode;
  logic [L-1:0] a, b, c;
  logic [L-1:0] x, y, x_filt;
  logic         out_vld;
  logic [7:0]   evt_cnt;
  logic         evt_sat;
  logic [L-1:0] x3, y3, xf3;
  logic         ov3;
  logic [2:0]   evt3;
  logic         sat3;

  int checks = 0;
  int errors = 0;
  logic [2*L-1:0] sb[$];

  typedef struct {
    logic [1:0] m;
    logic [3:0] a, b, c, ex, ey;
  } vec_t;
  vec_t tbl[10];

  logic_eval_lanes #(.LANES(L), .FILT_DEPTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .c(c),
    .x(x), .y(y), .x_filt(x_filt), .out_vld(out_vld),
    .cnt_clr(cnt_clr), .evt_cnt(evt_cnt), .evt_sat(evt_sat)
  );

  logic_eval_lanes #(.LANES(L), .FILT_DEPTH(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .c(c),
    .x(x3), .y(y3), .x_filt(xf3), .out_vld(ov3),
    .cnt_clr(cnt_clr), .evt_cnt(evt3), .evt_sat(sat3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_x(input logic [1:0] m, input logic [3:0] ia,
                                        input logic [3:0] ib, input logic [3:0] ic);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = int'(ia[i]) + int'(ib[i]) + int'(ic[i]);
      case (m)
        2'd0: r[i] = (ia[i] && ib[i]) || !ic[i];
        2'd1: r[i] = (n >= 2);
        2'd2: r[i] = (n % 2) == 1;
        default: r[i] = (ia[i] || ib[i]) && !ic[i];
      endcase
    end
    return r;
  endfunction

  // Scoreboard consumer: one result per cycle with out_vld high.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_vld === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result x=0x%0h y=0x%0h, expected none", x, y);
      end else begin
        logic [2*L-1:0] e;
        e = sb.pop_front();
        check("sb_x", 32'(x), 32'(e[7:4]));
        check("sb_y", 32'(y), 32'(e[3:0]));
      end
    end
  end

  task automatic cyc_exp(input logic e, input logic [1:0] m, input logic [3:0] ia,
                         input logic [3:0] ib, input logic [3:0] ic, input logic clr,
                         input logic [3:0] ex, input logic [3:0] ey);
    en = e; mode = m; a = ia; b = ib; c = ic; cnt_clr = clr;
    if (e) sb.push_back({ex, ey});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic e, input logic [1:0] m, input logic [3:0] ia,
                     input logic [3:0] ib, input logic [3:0] ic, input logic clr);
    cyc_exp(e, m, ia, ib, ic, clr, ref_x(m, ia, ib, ic), ~ic);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_xfilt"}, 32'(x_filt), 0);
    check({tag, "_vld"}, 32'(out_vld), 0);
    check({tag, "_cnt"}, 32'(evt_cnt), 0);
    check({tag, "_sat"}, 32'(evt_sat), 0);
    check({tag, "_cnt3"}, 32'(evt3), 0);
    check({tag, "_sat3"}, 32'(sat3), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cnt_clr = 1'b0; mode = '0; a = '0; b = '0; c = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
  endtask

  task automatic h4(input logic clr); cyc(1'b1, 2'd0, 4'hF, 4'hF, 4'hF, clr); endtask
  task automatic l4(input logic clr); cyc(1'b1, 2'd0, 4'h0, 4'h0, 4'hF, clr); endtask
  task automatic h1(); cyc(1'b1, 2'd0, 4'h1, 4'h1, 4'hF, 1'b0); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd0, 4'b0011, 4'b0001, 4'b0100, 4'b1011, 4'b1011};
    tbl[1] = '{2'd1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b1110};
    tbl[2] = '{2'd0, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b1110};
    tbl[3] = '{2'd2, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1110};
    tbl[4] = '{2'd3, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1110};
    tbl[5] = '{2'd1, 4'b1100, 4'b1010, 4'b0110, 4'b1110, 4'b1001};
    tbl[6] = '{2'd2, 4'b1100, 4'b1010, 4'b0110, 4'b0000, 4'b1001};
    tbl[7] = '{2'd3, 4'b1100, 4'b1010, 4'b0110, 4'b1000, 4'b1001};
    tbl[8] = '{2'd0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    tbl[9] = '{2'd2, 4'b0101, 4'b0011, 4'b1111, 4'b1001, 4'b0000};

    do_reset();

    // Basic latency and filter delay.
    cyc(1'b1, 2'd0, 4'b0011, 4'b0001, 4'b0100, 1'b0);
    check("lat_vld_early", 32'(out_vld), 0);
    cyc(1'b1, 2'd0, 4'b0011, 4'b0001, 4'b0100, 1'b0);
    check("lat_vld", 32'(out_vld), 1);
    check("lat_x", 32'(x), 32'hB);
    check("lat_y", 32'(y), 32'hB);
    cyc(1'b1, 2'd0, 4'b0011, 4'b0001, 4'b0100, 1'b0);
    cyc(1'b1, 2'd0, 4'b0011, 4'b0001, 4'b0100, 1'b0);
    check("filt_wait", 32'(x_filt), 0);
    cyc(1'b1, 2'd0, 4'b0011, 4'b0001, 4'b0100, 1'b0);
    check("filt_follow", 32'(x_filt), 32'hB);
    check("filt_cnt", 32'(evt_cnt), 3);

    // Mode vectors back to back, then with idle cycles between samples.
    for (int i = 0; i < 10; i++)
      cyc_exp(1'b1, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, tbl[i].ex, tbl[i].ey);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      cyc_exp(1'b1, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, tbl[i].ex, tbl[i].ey);
    end
    repeat (40)
      cyc(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom),
          4'($urandom), 1'b0);
    repeat (3) cyc(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0);
    check("sb_drain", 32'(sb.size()), 0);

    // Two-sample glitch is rejected; three-sample pulse passes.
    do_reset();
    h1(); h1();
    repeat (5) l4(1'b0);
    check("glitch_xfilt", 32'(x_filt), 0);
    check("glitch_cnt", 32'(evt_cnt), 0);
    h1(); h1(); h1();
    l4(1'b0); l4(1'b0);
    check("pulse_xfilt", 32'(x_filt), 32'h1);
    check("pulse_cnt", 32'(evt_cnt), 1);

    // Four simultaneous edges, then again with a same-cycle clear.
    do_reset();
    repeat (5) h4(1'b0);
    check("all4_cnt", 32'(evt_cnt), 4);
    check("all4_xfilt", 32'(x_filt), 32'hF);
    repeat (5) l4(1'b0);
    check("fall_xfilt", 32'(x_filt), 0);
    check("fall_cnt", 32'(evt_cnt), 4);
    repeat (4) h4(1'b0);
    h4(1'b1);
    check("clr_edge_cnt", 32'(evt_cnt), 4);
    h4(1'b1);
    check("clr_only_cnt", 32'(evt_cnt), 0);

    // Saturation on the narrow counter: 4 + 4 + 1 events.
    do_reset();
    repeat (5) h4(1'b0);
    check("sat_r1_cnt3", 32'(evt3), 4);
    check("sat_r1_sat3", 32'(sat3), 0);
    repeat (5) l4(1'b0);
    repeat (5) h4(1'b0);
    check("sat_r2_cnt", 32'(evt_cnt), 8);
    check("sat_r2_cnt3", 32'(evt3), 7);
    check("sat_r2_sat3", 32'(sat3), 1);
    repeat (5) l4(1'b0);
    repeat (5) h1();
    check("sat_r3_cnt", 32'(evt_cnt), 9);
    check("sat_r3_cnt3", 32'(evt3), 7);
    check("sat_r3_sat3", 32'(sat3), 1);
    l4(1'b1);
    check("sat_clr_cnt", 32'(evt_cnt), 0);
    check("sat_clr_cnt3", 32'(evt3), 0);
    check("sat_clr_sat3", 32'(sat3), 0);

    // Asynchronous reset with results in flight and a partially filled filter.
    do_reset();
    repeat (3) h4(1'b0);
    check("mid_vld", 32'(out_vld), 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    h4(1'b0);
    check("post_rst_vld_early", 32'(out_vld), 0);
    h4(1'b0);
    check("post_rst_vld", 32'(out_vld), 1);
    check("post_rst_x", 32'(x), 32'hF);
    h4(1'b0);
    check("post_rst_xfilt", 32'(x_filt), 0);

    repeat (3) cyc(1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0);
    check("sb_final_drain", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
